// File: rtl/led_chain_shifter_pkg.sv
// Shared types for the LED chain shifter: FSM states and stage width.
package led_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == SHIFT_LO) || (s == SHIFT_HI) || (s == LATCH);
  endfunction

endpackage

// File: rtl/led_chain_shifter_if.sv
// Handshake and board-pin bundle between display logic and the chain shifter.
interface led_chain_shifter_if #(
  parameter int NUM_BYTES = 2
);
  import led_pkg::*;

  localparam int W = BYTE_W * NUM_BYTES;

  logic         start;
  logic [W-1:0] data;
  logic         busy;
  logic         done;
  logic         sclk;
  logic         sdata;
  logic         latch;

  modport master (
    output start, data,
    input  busy, done, sclk, sdata, latch
  );

  modport slave (
    input  start, data,
    output busy, done, sclk, sdata, latch
  );

endinterface

// File: rtl/led_chain_shifter_clk_div_tick.sv
// Phase counter: tick is high in the last of every CLK_DIV cycles of a phase.
module clk_div_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == LAST);

  // Phase counter restarts on reset, on phase entry and after each tick
  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/led_chain_shifter.sv
// Serial driver for a chain of 8-bit shift-register stages with divided sclk,
// latch strobe and start/busy/done handshake.
module led_chain_shifter
  import led_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  led_chain_shifter_if.slave  bus
);

  localparam int W  = BYTE_W * NUM_BYTES;
  localparam int BW = $clog2(W) + 1;
  localparam logic [BW-1:0] BIT_END = BW'(W);

  state_t          state_r, state_next;
  logic [W-1:0]    shadow_r, shadow_next;
  logic [BW-1:0]   bit_cnt_r, bit_cnt_next;
  logic            tick_s;
  logic            clr_s;
  logic            busy_r, done_r, sclk_r, sdata_r, latch_r;
  logic            busy_next, done_next, sclk_next, sdata_next, latch_next;

  function automatic logic out_bit(input logic [W-1:0] s);
    return (MSB_FIRST != 0) ? s[W-1] : s[0];
  endfunction

  clk_div_tick #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Next-state, shadow shift and bit counting
  always_comb begin
    state_next   = state_r;
    shadow_next  = shadow_r;
    bit_cnt_next = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          shadow_next  = bus.data;
          bit_cnt_next = '0;
          state_next   = SHIFT_LO;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT_LO: begin
        if (tick_s) begin
          state_next = SHIFT_HI;
        end else begin
          state_next = SHIFT_LO;
        end
      end
      SHIFT_HI: begin
        if (tick_s) begin
          // Move the next bit to the output end once the stage has sampled
          if (MSB_FIRST != 0) begin
            shadow_next = {shadow_r[W-2:0], 1'b0};
          end else begin
            shadow_next = {1'b0, shadow_r[W-1:1]};
          end
          bit_cnt_next = bit_cnt_r + BW'(1);
          if (bit_cnt_next == BIT_END) begin
            state_next = LATCH;
          end else begin
            state_next = SHIFT_LO;
          end
        end else begin
          state_next = SHIFT_HI;
        end
      end
      LATCH: begin
        if (tick_s) begin
          state_next = DONE;
        end else begin
          state_next = LATCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign clr_s = (state_next != state_r);

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    busy_next  = is_busy_state(state_next);
    done_next  = (state_next == DONE);
    sclk_next  = (state_next == SHIFT_HI);
    latch_next = (state_next == LATCH);
    if ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) begin
      sdata_next = out_bit(shadow_next);
    end else begin
      sdata_next = 1'b0;
    end
  end

  // State, datapath and registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shadow_r  <= '0;
      bit_cnt_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sclk_r    <= 1'b0;
      sdata_r   <= 1'b0;
      latch_r   <= 1'b0;
    end else begin
      state_r   <= state_next;
      shadow_r  <= shadow_next;
      bit_cnt_r <= bit_cnt_next;
      busy_r    <= busy_next;
      done_r    <= done_next;
      sclk_r    <= sclk_next;
      sdata_r   <= sdata_next;
      latch_r   <= latch_next;
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sclk  = sclk_r;
  assign bus.sdata = sdata_r;
  assign bus.latch = latch_r;

endmodule
